// File: rtl/button_press_classifier_pkg.sv
// Shared types and helpers for the button press classifier and its timing blocks.
// Holds the FSM state encoding and the ms-to-cycles conversion.
package button_pkg;

    // 2'd3 is unused and sends the FSM back to idle.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2,
        ST_BAD     = 2'd3
    } state_t;

    function automatic int ms_to_cycles(input int clk_freq, input int ms);
        return (clk_freq / 1000) * ms;
    endfunction

endpackage

// File: rtl/button_press_classifier_if.sv
// Button-in / event-out bundle between the debounce stage, the classifier
// and the game/menu FSM. master drives the button, slave classifies.
interface button_press_classifier_if;

    logic btn_pulse;
    logic btn_level;
    logic short_press;
    logic long_press;
    logic repeat_tick;
    logic hold_active;

    modport master (
        output btn_pulse,
        output btn_level,
        input  short_press,
        input  long_press,
        input  repeat_tick,
        input  hold_active
    );

    modport slave (
        input  btn_pulse,
        input  btn_level,
        output short_press,
        output long_press,
        output repeat_tick,
        output hold_active
    );

endinterface

// File: rtl/button_press_classifier_ms_tick_gen.sv
// Millisecond prescaler: one-cycle tick every CPM clocks, synchronous clear.
// Ports: clk, rst_n (async, active low), clear (in), tick (out).
module ms_tick_gen
    import button_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CPM = ms_to_cycles(CLK_FREQ, 1);
    localparam int W   = $clog2(CPM);
    localparam logic [W-1:0] LAST = W'(CPM - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = !clear && (cnt == LAST);

endmodule

// File: rtl/button_press_classifier.sv
// Classifies debounced button presses as short, long or held-repeat.
// Ports: clk, rst_n (async, active low), bus (slave: btn_pulse/btn_level in,
// short_press/long_press/repeat_tick/hold_active out, all registered).
module button_press_classifier
    import button_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int LONG_MS   = 3000,
    parameter int REPEAT_MS = 250
) (
    input  logic                      clk,
    input  logic                      rst_n,
    button_press_classifier_if.slave  bus
);

    localparam int MS_W  = $clog2(LONG_MS + 1);
    localparam int REP_W = (REPEAT_MS > 0) ? $clog2(REPEAT_MS + 1) : 1;
    localparam bit REP_EN = (REPEAT_MS > 0);

    localparam logic [MS_W-1:0] MS_LAST = MS_W'(LONG_MS - 1);
    localparam logic [MS_W-1:0] MS_MAX  = MS_W'(LONG_MS);
    localparam logic [REP_W-1:0] REP_LAST =
        REP_W'((REPEAT_MS > 0) ? REPEAT_MS - 1 : 0);

    state_t           state;
    state_t           state_n;
    logic             ms_tick;
    logic             ms_clear;
    logic [MS_W-1:0]  ms_cnt;
    logic [REP_W-1:0] rep_cnt;

    logic short_n;
    logic long_n;
    logic rep_n;
    logic hold_n;
    logic short_q;
    logic long_q;
    logic rep_q;
    logic hold_q;

    // Prescaler is phase-locked to the accepting edge and keeps running
    // through HELD so repeat ticks stay on whole-ms boundaries.
    assign ms_clear = (state != ST_PRESSED) && (state != ST_HELD);

    ms_tick_gen #(
        .CLK_FREQ (CLK_FREQ)
    ) u_ms_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (ms_clear),
        .tick  (ms_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Release is checked before the threshold, so a release on the
    // threshold edge yields a short press and a release on a repeat
    // boundary suppresses the tick.
    always_comb begin
        state_n = state;
        short_n = 1'b0;
        long_n  = 1'b0;
        rep_n   = 1'b0;
        hold_n  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.btn_pulse) begin
                    state_n = ST_PRESSED;
                end
            end
            ST_PRESSED: begin
                if (!bus.btn_level) begin
                    short_n = 1'b1;
                    state_n = ST_IDLE;
                end else if (ms_tick && ms_cnt == MS_LAST) begin
                    long_n  = 1'b1;
                    hold_n  = 1'b1;
                    state_n = ST_HELD;
                end
            end
            ST_HELD: begin
                if (!bus.btn_level) begin
                    state_n = ST_IDLE;
                end else begin
                    hold_n = 1'b1;
                    if (REP_EN && ms_tick && rep_cnt == REP_LAST) begin
                        rep_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ms_cnt <= '0;
        end else if (state == ST_PRESSED || state == ST_HELD) begin
            if (ms_tick && ms_cnt != MS_MAX) begin
                ms_cnt <= ms_cnt + 1'b1;
            end
        end else begin
            ms_cnt <= '0;
        end
    end

    // Zero on entry to HELD, so the first repeat lands REPEAT_MS after
    // long_press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt <= '0;
        end else if (state != ST_HELD) begin
            rep_cnt <= '0;
        end else if (ms_tick) begin
            if (rep_cnt == REP_LAST) begin
                rep_cnt <= '0;
            end else begin
                rep_cnt <= rep_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            short_q <= 1'b0;
            long_q  <= 1'b0;
            rep_q   <= 1'b0;
            hold_q  <= 1'b0;
        end else begin
            short_q <= short_n;
            long_q  <= long_n;
            rep_q   <= rep_n;
            hold_q  <= hold_n;
        end
    end

    assign bus.short_press = short_q;
    assign bus.long_press  = long_q;
    assign bus.repeat_tick = rep_q;
    assign bus.hold_active = hold_q;

endmodule

// File: tb/tb_button_press_classifier.sv
// Self-checking bench for button_press_classifier.
// Drives press scenarios and random presses against a timing-rule model.
module tb_button_press_classifier;

    localparam int CLK_FREQ  = 10_000;
    localparam int LONG_MS   = 5;
    localparam int REPEAT_MS = 2;
    localparam int CPM       = CLK_FREQ / 1000;
    localparam int LONG_CYC  = LONG_MS * CPM;
    localparam int REP_CYC   = REPEAT_MS * CPM;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    button_press_classifier_if bif ();

    button_press_classifier #(
        .CLK_FREQ  (CLK_FREQ),
        .LONG_MS   (LONG_MS),
        .REPEAT_MS (REPEAT_MS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    int checks = 0;
    int passes = 0;
    int cyc = 0;

    bit m_active = 0;
    bit m_held = 0;
    int m_t0 = 0;
    logic [3:0] exp_v = 4'b0;
    logic [3:0] obs;

    int n_short = 0;
    int n_long = 0;
    int n_rep = 0;

    assign obs = {bif.short_press, bif.long_press,
                  bif.repeat_tick, bif.hold_active};

    // Expected outputs after an edge, from elapsed time since the press.
    task automatic model_edge(input bit p, input bit l);
        int e;
        bit es, el, er;
        es = 0;
        el = 0;
        er = 0;
        cyc++;
        if (!m_active) begin
            if (p) begin
                m_active = 1;
                m_held = 0;
                m_t0 = cyc;
            end
        end else begin
            e = cyc - m_t0;
            if (!l) begin
                es = !m_held;
                m_active = 0;
                m_held = 0;
            end else if (!m_held && e == LONG_CYC) begin
                el = 1;
                m_held = 1;
            end else if (m_held && REPEAT_MS > 0
                         && e > LONG_CYC
                         && (e - LONG_CYC) % REP_CYC == 0) begin
                er = 1;
            end
        end
        exp_v = {es, el, er, m_held};
    endtask

    task automatic model_reset();
        m_active = 0;
        m_held = 0;
        exp_v = 4'b0;
    endtask

    task automatic clear_counts();
        n_short = 0;
        n_long = 0;
        n_rep = 0;
    endtask

    task automatic tick(input bit p, input bit l);
        bif.btn_pulse = p;
        bif.btn_level = l;
        @(posedge clk);
        model_edge(p, l);
        #1;
        n_short += int'(bif.short_press);
        n_long += int'(bif.long_press);
        n_rep += int'(bif.repeat_tick);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 12; i++) begin
            bif.btn_level = 1'b1;
            bif.btn_pulse = i[0];
            @(posedge clk);
            #1;
            checks++;
            if (obs !== 4'b0) begin
                $display("FAIL reset_hold i=%0d got=%b want=%b", i, obs, 4'b0);
            end else begin
                passes++;
            end
        end
        #2 rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 30; i++) begin
            tick(1'b0, 1'b1);
            checks++;
            if (obs !== exp_v) begin
                $display("FAIL reset_nopulse cyc=%0d got=%b want=%b", cyc, obs, exp_v);
            end else begin
                passes++;
            end
        end
    endtask

    task automatic test_short();
        clear_counts();
        for (int i = 0; i < 25; i++) begin
            tick(i == 0, i < 20);
            checks++;
            if (obs !== exp_v) begin
                $display("FAIL short cyc=%0d got=%b want=%b", cyc, obs, exp_v);
            end else begin
                passes++;
            end
        end
        checks++;
        if (n_short != 1 || n_long != 0 || n_rep != 0) begin
            $display("FAIL short_counts got=%0d/%0d/%0d want=1/0/0", n_short, n_long, n_rep);
        end else begin
            passes++;
        end
    endtask

    task automatic test_long_hold(input bit extra);
        bit p;
        clear_counts();
        for (int i = 0; i < 106; i++) begin
            p = (i == 0) || (extra && (i == 20 || i == 60));
            tick(p, i <= 100);
            checks++;
            if (obs !== exp_v) begin
                $display("FAIL long_hold x=%0d cyc=%0d got=%b want=%b", extra, cyc, obs, exp_v);
            end else begin
                passes++;
            end
        end
        checks++;
        if (n_short != 0 || n_long != 1 || n_rep != 2) begin
            $display("FAIL long_counts x=%0d got=%0d/%0d/%0d want=0/1/2", extra, n_short, n_long, n_rep);
        end else begin
            passes++;
        end
    endtask

    task automatic test_boundary();
        int r;
        for (int k = 0; k < 2; k++) begin
            r = LONG_CYC + k;
            clear_counts();
            for (int i = 0; i < r + 5; i++) begin
                tick(i == 0, i < r);
                checks++;
                if (obs !== exp_v) begin
                    $display("FAIL boundary r=%0d cyc=%0d got=%b want=%b", r, cyc, obs, exp_v);
                end else begin
                    passes++;
                end
            end
            checks++;
            if (n_short != 1 - k || n_long != k) begin
                $display("FAIL boundary_counts r=%0d got=%0d/%0d want=%0d/%0d", r, n_short, n_long, 1 - k, k);
            end else begin
                passes++;
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i <= 75; i++) begin
            tick(i == 0, 1'b1);
            checks++;
            if (obs !== exp_v) begin
                $display("FAIL pre_reset cyc=%0d got=%b want=%b", cyc, obs, exp_v);
            end else begin
                passes++;
            end
        end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (bif.hold_active !== 1'b0) begin
            $display("FAIL async_reset got=%b want=0", bif.hold_active);
        end else begin
            passes++;
        end
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        model_reset();
        clear_counts();
        for (int i = 0; i < 30; i++) begin
            tick(1'b0, 1'b1);
            checks++;
            if (obs !== exp_v) begin
                $display("FAIL post_reset cyc=%0d got=%b want=%b", cyc, obs, exp_v);
            end else begin
                passes++;
            end
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0);
        end
        checks++;
        if (n_short + n_long + n_rep != 0) begin
            $display("FAIL post_reset_counts got=%0d want=0", n_short + n_long + n_rep);
        end else begin
            passes++;
        end
    endtask

    task automatic test_random();
        int h;
        int gap;
        bit p;
        for (int n = 0; n < 15; n++) begin
            h = int'($urandom_range(1, 110));
            gap = int'($urandom_range(1, 4));
            for (int i = 0; i < h + gap; i++) begin
                p = (i == 0) || (i < h && $urandom_range(0, 7) == 0);
                tick(p, i < h);
                checks++;
                if (obs !== exp_v) begin
                    $display("FAIL random n=%0d h=%0d cyc=%0d got=%b want=%b", n, h, cyc, obs, exp_v);
                end else begin
                    passes++;
                end
            end
        end
    endtask

    initial begin
        bif.btn_pulse = 1'b0;
        bif.btn_level = 1'b0;
        test_reset();
        test_short();
        test_long_hold(1'b0);
        test_boundary();
        test_long_hold(1'b1);
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
